chan_mux_rr: RTL

- Parametrised N-channel, W-bit multiplexer and successor to the fixed 2:1/4:1 word muxes.
- Adds a valid/ready handshake on every channel, three selection modes (manual select, fixed priority, round-robin) and a one-deep registered output stage.
- Sits between multiple data producers and a single downstream consumer, for example merging result streams onto one bus.

---
 rtl/chan_mux_rr.sv | 94 +++++++++
 1 files changed

// File: rtl/chan_mux_rr.sv
// N-channel valid/ready mux with manual, fixed-priority and round-robin selection into a one-deep output register.
// One cycle of latency from input handshake to out_valid; a stalled output holds its word and lowers every in_ready.
module chan_mux_rr #(
  parameter int NCH  = 4,
  parameter int W    = 4,
  parameter int SELW = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int CNTW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [SELW-1:0]   sel,
  input  logic [NCH*W-1:0]  in_data,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_chan,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNTW-1:0]   xfer_cnt
);

  localparam logic [1:0] MODE_MAN = 2'd0;
  localparam logic [1:0] MODE_PRI = 2'd1;

  logic [SELW-1:0] last;
  logic [SELW-1:0] gnt_idx;
  logic            gnt_vld;
  logic            load_en;
  logic            load;
  int              j;

  assign load_en = !out_valid || out_ready;
  assign load    = gnt_vld && load_en && !rst;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    j       = 0;
    case (mode)
      MODE_MAN: begin
        if (int'(sel) < NCH && in_valid[sel]) begin
          gnt_vld = 1'b1;
          gnt_idx = sel;
        end
      end
      MODE_PRI: begin
        // Walk downwards so the lowest valid index wins.
        for (int i = NCH - 1; i >= 0; i--) begin
          if (in_valid[i]) begin
            gnt_vld = 1'b1;
            gnt_idx = SELW'(i);
          end
        end
      end
      default: begin
        for (int k = 1; k <= NCH; k++) begin
          j = int'(last) + k;
          if (j >= NCH) j = j - NCH;
          if (!gnt_vld && in_valid[j]) begin
            gnt_vld = 1'b1;
            gnt_idx = SELW'(j);
          end
        end
      end
    endcase
  end

  always_comb begin
    in_ready = '0;
    if (load) in_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      xfer_cnt  <= '0;
      last      <= SELW'(NCH - 1);
    end else begin
      if (out_valid && out_ready) xfer_cnt <= xfer_cnt + CNTW'(1);
      if (load) begin
        out_data  <= in_data[int'(gnt_idx)*W +: W];
        out_chan  <= gnt_idx;
        out_valid <= 1'b1;
        if (mode[1]) last <= gnt_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
